m_ifetch_queue: RTL and testbench
=================================

M_IFETCH_QUEUE -- requirements
Module: m_ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count; power of two, 2..16.
REQ-002 SHALL have parameter RST_PC, default 32'h0, fetch PC after reset.
REQ-003 SHALL have port w_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port w_rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port w_redir, input, 1, redirect request (taken branch).
REQ-006 SHALL have port w_redir_pc, input, 32, new fetch PC; sampled when w_redir=1.
REQ-007 SHALL have port w_stop, input, 1, suppresses new fetch requests (halt).
REQ-008 SHALL have port w_mem_req, output, 1, instruction memory read request.
REQ-009 SHALL have port w_mem_addr, output, 12, word address = fetch PC[13:2].
REQ-010 SHALL have port w_mem_ack, input, 1, memory read-data-valid strobe.
REQ-011 SHALL have port w_mem_data, input, 32, instruction word; valid when w_mem_ack=1.
REQ-012 SHALL have port w_deq, input, 1, consumer pops head entry.
REQ-013 SHALL have port w_valid, output, 1, head entry present.
REQ-014 SHALL have port w_ir, output, 32, head instruction; 32'h0 when w_valid=0.
REQ-015 SHALL have port w_pc, output, 32, PC of head instruction.
REQ-016 SHALL have port w_pc4, output, 32, w_pc+4.

Function
REQ-017 SHALL hold fetch PC register r_fpc, at most one outstanding memory request, and a DEPTH-entry FIFO of {pc, ir}.
REQ-018 SHALL implement FSM states IDLE, WAIT, DISCARD.
REQ-019 IDLE: SHALL assert w_mem_req and enter WAIT when w_stop=0, w_redir=0, and occupancy < DEPTH.
REQ-020 WAIT: SHALL hold w_mem_req=1 and w_mem_addr stable until w_mem_ack.
REQ-021 On w_mem_ack in WAIT, SHALL push {r_fpc, w_mem_data}, set r_fpc <= r_fpc+4 (32-bit wrap), and return to IDLE.
REQ-022 A new request SHALL be issuable in the cycle after an ack (back-to-back, one word per two cycles minimum).
REQ-023 On w_redir in IDLE, SHALL flush FIFO, set r_fpc <= w_redir_pc, and stay IDLE.
REQ-024 On w_redir in WAIT without ack, SHALL flush FIFO, load r_fpc, deassert w_mem_req, and enter DISCARD.
REQ-025 On w_redir in WAIT with simultaneous ack, SHALL drop the acked word, flush, load r_fpc, and go to IDLE.
REQ-026 DISCARD: SHALL drop the next acked word without pushing, go to IDLE; a further w_redir SHALL only reload r_fpc.
REQ-027 w_redir SHALL take priority over w_deq and w_mem_ack in the same cycle.
REQ-028 w_deq with w_valid=0 SHALL be ignored; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-029 A push SHALL never overflow; requests are issued only when a slot is reserved.
REQ-030 w_stop SHALL NOT cancel an outstanding request; its ack SHALL still be pushed.
REQ-031 Head outputs SHALL be registered-FIFO reads: pushed word visible on w_valid/w_ir in the cycle after ack.

Reset
REQ-032 On w_rst=0, SHALL asynchronously set r_fpc=RST_PC, FSM=IDLE, occupancy=0, pointers=0.
REQ-033 During reset, SHALL drive w_mem_req=0, w_valid=0, w_ir=0, w_pc=0, w_pc4=4.
REQ-034 Ack arriving during or in the first cycle after reset release SHALL be discarded.

Configuration
REQ-035 Macro IFQ_BYPASS_EN defined: when FIFO is empty, FSM in WAIT, w_mem_ack=1, and no redirect, SHALL present w_mem_data/r_fpc on w_ir/w_pc combinationally that cycle with w_valid=1; if w_deq=1 that cycle, word SHALL NOT be pushed.
REQ-036 Macro IFQ_BYPASS_EN undefined: behaviour per REQ-031 only; no combinational path from w_mem_data to w_ir.

Verification
REQ-037 Reset release, memory ack latency 1, w_deq=0 -> exactly 4 requests (addr 0,1,2,3), then w_mem_req=0; head w_pc=0.
REQ-038 Full FIFO, w_deq pulsed once -> exactly one new request at addr 4; head w_pc becomes 4.
REQ-039 w_redir_pc=32'h40 while WAIT for addr 2 -> FSM DISCARD, ack data dropped, next request addr 16, w_valid=0 until its ack.
REQ-040 w_redir and w_mem_ack same cycle -> acked word absent from FIFO; next request addr = w_redir_pc[13:2].
REQ-041 w_stop=1 during WAIT -> pending word pushed, no further w_mem_req while w_stop=1.
REQ-042 With IFQ_BYPASS_EN, empty FIFO, ack data 32'h2001000A with w_deq=1 -> w_valid=1, w_ir=32'h2001000A same cycle, occupancy stays 0.

Source files
------------

// File: rtl/m_ifetch_queue.sv
// rtl/m_ifetch_queue.sv - instruction fetch unit with prefetch FIFO and redirect handling
//
// Purpose:
//   Walks a fetch PC through instruction memory, one outstanding read at a
//   time, and queues returned words with their PCs for a consumer. A redirect
//   (taken branch) flushes the queue and reloads the fetch PC; a read that is
//   still in flight when a redirect arrives is swallowed via the DISCARD state.
//
// Optional feature (macro IFQ_BYPASS_EN):
//   When defined, a word returning into an empty queue is shown on the head
//   outputs in the same cycle, and is not queued if the consumer pops it then.
//   When undefined, head outputs come only from the queue storage.
//
// Ports:
//   w_clk        in   1   clock, rising edge
//   w_rst        in   1   asynchronous active-low reset
//   w_redir      in   1   redirect request
//   w_redir_pc   in  32   new fetch PC, sampled with w_redir
//   w_stop       in   1   suppress new fetch requests
//   w_mem_req    out  1   memory read request (held until w_mem_ack)
//   w_mem_addr   out 12   word address, fetch PC[13:2]
//   w_mem_ack    in   1   memory read data valid
//   w_mem_data   in  32   memory read data
//   w_deq        in   1   consumer pops head entry
//   w_valid      out  1   head entry present
//   w_ir         out 32   head instruction, zero when empty
//   w_pc         out 32   head PC, zero when empty
//   w_pc4        out 32   w_pc + 4

module m_ifetch_queue #(
  parameter int          DEPTH  = 4,
  parameter logic [31:0] RST_PC = 32'h0
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_redir,
  input  logic [31:0] w_redir_pc,
  input  logic        w_stop,
  output logic        w_mem_req,
  output logic [11:0] w_mem_addr,
  input  logic        w_mem_ack,
  input  logic [31:0] w_mem_data,
  input  logic        w_deq,
  output logic        w_valid,
  output logic [31:0] w_ir,
  output logic [31:0] w_pc,
  output logic [31:0] w_pc4
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_fpc;

  logic [AW:0]   r_cnt;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [31:0]   r_pc_mem [DEPTH];
  logic [31:0]   r_ir_mem [DEPTH];

  logic fifo_empty;
  logic ack_wait;
  logic issue;
  logic push;
  logic pop;

  assign fifo_empty = (r_cnt == '0);
  assign ack_wait   = (r_state == S_WAIT) && w_mem_ack;

  // A request is only started when a queue slot is free; with a single
  // outstanding read and pops only ever freeing space, the slot stays
  // reserved until the ack, so a push can never overflow.
  assign issue = (r_state == S_IDLE) && !w_redir && !w_stop && (r_cnt < FULL_CNT);

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass = fifo_empty && ack_wait && !w_redir;
  // A bypassed word consumed in the same cycle never enters the queue.
  assign push   = ack_wait && !w_redir && !(bypass && w_deq);
`else
  assign push   = ack_wait && !w_redir;
`endif

  // Pops from an empty queue are ignored; redirect flushes instead.
  assign pop = w_deq && !fifo_empty && !w_redir;

  // Fetch control: request flag tracks the WAIT state so it is a flop output.
  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_fpc   <= RST_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_redir) begin
            r_fpc <= w_redir_pc;
          end else if (issue) begin
            r_state <= S_WAIT;
            r_req   <= 1'b1;
          end
        end
        S_WAIT: begin
          if (w_redir) begin
            // The in-flight word belongs to the old path; if it has not come
            // back yet it must be swallowed when it does.
            r_fpc   <= w_redir_pc;
            r_req   <= 1'b0;
            r_state <= w_mem_ack ? S_IDLE : S_DISCARD;
          end else if (w_mem_ack) begin
            r_fpc   <= r_fpc + 32'd4;
            r_req   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_DISCARD: begin
          if (w_redir) begin
            r_fpc <= w_redir_pc;
          end
          if (w_mem_ack) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // Queue pointers and occupancy; redirect flush wins over push/pop.
  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (w_redir) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (pop) begin
        r_rd <= r_rd + 1'b1;
      end
      if (push && !pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!push && pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Queue storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge w_clk) begin
    if (push) begin
      r_pc_mem[r_wr] <= r_fpc;
      r_ir_mem[r_wr] <= w_mem_data;
    end
  end

  assign w_mem_req  = r_req;
  assign w_mem_addr = r_fpc[13:2];

`ifdef IFQ_BYPASS_EN
  assign w_valid = !fifo_empty || bypass;
  assign w_ir    = bypass ? w_mem_data : (fifo_empty ? 32'h0 : r_ir_mem[r_rd]);
  assign w_pc    = bypass ? r_fpc      : (fifo_empty ? 32'h0 : r_pc_mem[r_rd]);
`else
  assign w_valid = !fifo_empty;
  assign w_ir    = fifo_empty ? 32'h0 : r_ir_mem[r_rd];
  assign w_pc    = fifo_empty ? 32'h0 : r_pc_mem[r_rd];
`endif

  assign w_pc4 = w_pc + 32'd4;

endmodule

// File: tb/tb_m_ifetch_queue.sv
// tb/tb_m_ifetch_queue.sv - randomized self-checking bench for m_ifetch_queue

module tb_m_ifetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        w_clk = 1'b0;
  logic        w_rst;
  logic        w_redir;
  logic [31:0] w_redir_pc;
  logic        w_stop;
  logic        w_mem_req;
  logic [11:0] w_mem_addr;
  logic        w_mem_ack;
  logic [31:0] w_mem_data;
  logic        w_deq;
  logic        w_valid;
  logic [31:0] w_ir;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;

  m_ifetch_queue #(.DEPTH(DEPTH), .RST_PC(RST_PC)) u_dut (
    .w_clk      (w_clk),
    .w_rst      (w_rst),
    .w_redir    (w_redir),
    .w_redir_pc (w_redir_pc),
    .w_stop     (w_stop),
    .w_mem_req  (w_mem_req),
    .w_mem_addr (w_mem_addr),
    .w_mem_ack  (w_mem_ack),
    .w_mem_data (w_mem_data),
    .w_deq      (w_deq),
    .w_valid    (w_valid),
    .w_ir       (w_ir),
    .w_pc       (w_pc),
    .w_pc4      (w_pc4)
  );

  always #5 w_clk = ~w_clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: queue of fetched words, fetch PC, and whether a read is
  // live (will be queued) or doomed (will be thrown away when it returns).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc;
  bit          m_pend;
  bit          m_doom;

  // Memory responder and request log.
  bit          mem_busy;
  int          mem_lat;
  logic [11:0] req_log[$];

  // Stimulus knobs; forced values override random ones when >= 0.
  int          lat_fix = -1;
  int          p_deq   = 0;
  int          p_redir = 0;
  int          p_stop  = 0;
  int          f_deq   = -1;
  int          f_redir = -1;
  int          f_stop  = -1;
  logic [31:0] f_pc    = 32'h0;
  bit          redir_on_ack = 1'b0;
  bit          use_fdata    = 1'b0;
  logic [31:0] f_data       = 32'h0;

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFF8;
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  function automatic void model_update(bit rd, logic [31:0] rpc, bit st, bit dq, bit ack,
                                       logic [31:0] dat);
    int sz0;
    bit byp;
    sz0 = mq.size();
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = (sz0 == 0) && m_pend && ack && !rd && dq;
`endif
    if (rd) begin
      mq.delete();
      m_fpc  = rpc;
      m_doom = (m_pend || m_doom) && !ack;
      m_pend = 1'b0;
    end else begin
      if (dq && sz0 > 0) void'(mq.pop_front());
      if (m_doom) begin
        if (ack) m_doom = 1'b0;
      end else if (m_pend) begin
        if (ack) begin
          if (!byp) mq.push_back('{pc: m_fpc, ir: dat});
          m_fpc  = m_fpc + 32'd4;
          m_pend = 1'b0;
        end
      end else if (!st && sz0 < DEPTH) begin
        m_pend = 1'b1;
      end
    end
  endfunction

  // One clock cycle; entered and left shortly after a rising edge.
  task automatic step();
    bit          ack, rd, dq, st, trig;
    logic [31:0] dat, rpc;
    logic        e_valid;
    logic [31:0] e_ir, e_pc;

    if (!mem_busy && w_mem_req) begin
      mem_busy = 1'b1;
      mem_lat  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 2));
      req_log.push_back(w_mem_addr);
    end
    ack = 1'b0;
    dat = use_fdata ? f_data : $urandom;
    if (mem_busy) begin
      if (mem_lat == 0) begin
        ack      = 1'b1;
        mem_busy = 1'b0;
      end else begin
        mem_lat--;
      end
    end

    trig = redir_on_ack && ack;
    if (trig) redir_on_ack = 1'b0;
    rd  = (f_redir >= 0) ? f_redir[0] : ($urandom_range(0, 99) < p_redir);
    rd  = rd || trig;
    rpc = (f_redir >= 0 || trig) ? f_pc : rand_pc();
    dq  = (f_deq  >= 0) ? f_deq[0]  : ($urandom_range(0, 99) < p_deq);
    st  = (f_stop >= 0) ? f_stop[0] : ($urandom_range(0, 99) < p_stop);

    w_redir    = rd;
    w_redir_pc = rpc;
    w_deq      = dq;
    w_stop     = st;
    w_mem_ack  = ack;
    w_mem_data = dat;
    #1;

    e_valid = (mq.size() > 0);
    e_ir    = e_valid ? mq[0].ir : 32'h0;
    e_pc    = e_valid ? mq[0].pc : 32'h0;
`ifdef IFQ_BYPASS_EN
    if (mq.size() == 0 && m_pend && ack && !rd) begin
      e_valid = 1'b1;
      e_ir    = dat;
      e_pc    = m_fpc;
    end
`endif
    check_val("mem_req",  32'(w_mem_req),  32'(m_pend));
    check_val("mem_addr", 32'(w_mem_addr), 32'(m_fpc[13:2]));
    check_val("valid",    32'(w_valid),    32'(e_valid));
    check_val("ir",       w_ir,            e_ir);
    check_val("pc",       w_pc,            e_pc);
    check_val("pc4",      w_pc4,           e_pc + 32'd4);

    @(posedge w_clk);
    model_update(rd, rpc, st, dq, ack, dat);
    #1;
  endtask

  task automatic do_reset();
    w_rst      = 1'b0;
    w_redir    = 1'b0;
    w_redir_pc = 32'h0;
    w_stop     = 1'b0;
    w_deq      = 1'b1;
    w_mem_ack  = 1'b1;
    w_mem_data = 32'hDEAD_BEEF;
    #1;
    check_val("rst_mem_req", 32'(w_mem_req), 32'h0);
    check_val("rst_valid",   32'(w_valid),   32'h0);
    check_val("rst_ir",      w_ir,           32'h0);
    check_val("rst_pc",      w_pc,           32'h0);
    check_val("rst_pc4",     w_pc4,          32'h4);
    repeat (2) @(posedge w_clk);
    @(negedge w_clk);
    w_rst = 1'b1;
    // The ack still high across the first edge after release must be ignored.
    @(posedge w_clk);
    #1;
    w_mem_ack = 1'b0;
    w_deq     = 1'b0;
    #1;
    check_val("rel_valid",   32'(w_valid),   32'h0);
    check_val("rel_mem_req", 32'(w_mem_req), 32'h1);
    // Model: idle with room and no stop issues the first fetch at that edge.
    mq.delete();
    m_fpc    = RST_PC;
    m_pend   = 1'b1;
    m_doom   = 1'b0;
    mem_busy = 1'b0;
    req_log.delete();
  endtask

  initial begin
    int guard;
    int n0;

    do_reset();

    // Fill to capacity with latency 1 and no consumer.
    lat_fix = 1;
    repeat (20) step();
    check_val("fill_nreq", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < req_log.size(); i++)
      check_val("fill_addr", 32'(req_log[i]), 32'(i));
    check_val("fill_req_low", 32'(w_mem_req), 32'h0);
    check_val("fill_head_pc", w_pc, 32'h0);

    // One pop frees exactly one slot.
    req_log.delete();
    f_deq = 1;
    step();
    f_deq = -1;
    repeat (20) step();
    check_val("pop_nreq", 32'(req_log.size()), 32'd1);
    if (req_log.size() > 0) check_val("pop_addr", 32'(req_log[0]), 32'd4);
    check_val("pop_head_pc", w_pc, 32'h4);

    // Redirect while waiting on address 2 -> in-flight word dropped.
    do_reset();
    lat_fix = 2;
    guard = 0;
    while (req_log.size() < 3 && guard < 60) begin step(); guard++; end
    check_val("dis_wait_addr", 32'(w_mem_addr), 32'd2);
    f_redir = 1;
    f_pc    = 32'h40;
    step();
    f_redir = -1;
    check_val("dis_req_low", 32'(w_mem_req), 32'h0);
    req_log.delete();
    guard = 0;
    while (req_log.size() < 1 && guard < 60) begin step(); guard++; end
    check_val("dis_nreq", 32'(req_log.size()), 32'd1);
    if (req_log.size() > 0) check_val("dis_addr", 32'(req_log[0]), 32'd16);
    check_val("dis_valid", 32'(w_valid), 32'h0);

    // Redirect coinciding with an ack.
    do_reset();
    lat_fix      = 1;
    f_pc         = 32'h0000_1230;
    redir_on_ack = 1'b1;
    guard = 0;
    while (redir_on_ack && guard < 60) begin step(); guard++; end
    check_val("ra_fired", 32'(redir_on_ack), 32'h0);
    req_log.delete();
    guard = 0;
    while (req_log.size() < 1 && guard < 60) begin step(); guard++; end
    if (req_log.size() > 0) check_val("ra_addr", 32'(req_log[0]), 32'h48C);
    else check_val("ra_nreq", 32'(req_log.size()), 32'd1);
    check_val("ra_valid", 32'(w_valid), 32'h0);

    // Stop during an outstanding read: word still queued, no new requests.
    do_reset();
    lat_fix = 3;
    f_stop  = 1;
    repeat (15) step();
    n0 = req_log.size();
    check_val("stop_nreq",  32'(n0),         32'd1);
    check_val("stop_req",   32'(w_mem_req),  32'h0);
    check_val("stop_valid", 32'(w_valid),    32'h1);
    check_val("stop_pc",    w_pc,            32'h0);
    f_stop = -1;

`ifdef IFQ_BYPASS_EN
    // Empty queue consumer takes the word straight from memory.
    do_reset();
    lat_fix   = 1;
    use_fdata = 1'b1;
    f_data    = 32'h2001_000A;
    f_deq     = 1;
    repeat (8) step();
    check_val("byp_empty", 32'(mq.size()), 32'd0);
    f_deq     = -1;
    use_fdata = 1'b0;
`endif

    // Randomized traffic.
    do_reset();
    lat_fix = -1;
    p_deq   = 50;
    p_redir = 4;
    p_stop  = 10;
    repeat (3000) step();
    p_deq = 90;
    repeat (500) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
